mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Memory-stage data access unit between the M-stage pipeline registers and the SRAM-like data bus.
//  Decodes load/store opcode, checks alignment (adel/ades + bad address), builds size/strobe/replicated store data.
//  Runs req/addr_ok/data_ok handshake, stalls pipeline until done, returns sign/zero-extended load data to M/W register.
// PARAMETERS
//  ADDR_W   32  bus address width
//  DATA_W   32  bus data width (fixed 32; byte lanes = 4)
// PORTS
//  clk          in   1       clock; all state on posedge
//  rst          in   1       asynchronous, active-low reset
//  op_i         in   6       M-stage opcode (LB 100000 LBU 100100 LH 100001 LHU 100101 LW 100011 SB 101000 SH 101001 SW 101011)
//  addr_i       in   32      effective address (M-stage ALU out)
//  wdata_i      in   32      store data (unreplicated)
//  mem_en_i     in   1       access valid (already gated by exception flush)
//  mem_we_i     in   1       1 = store, 0 = load
//  flush_i      in   1       pipeline flush (exception/interrupt) this cycle
//  stall_ext_i  in   1       pipeline held by a source other than this unit
//  rdata_o      out  32      extended load result, valid while stallreq_o=0 after a load
//  adel_o       out  1       load/fetch-data address error
//  ades_o       out  1       store address error
//  bad_addr_o   out  32      faulting address (= addr_i when adel_o|ades_o, else 0)
//  stallreq_o   out  1       hold pipeline: access outstanding
//  data_req     out  1       bus request
//  data_wr      out  1       bus write
//  data_size    out  2       0 byte, 1 half, 2 word
//  data_addr    out  32      bus address (= addr_i)
//  data_wstrb   out  4       byte strobes (stores), 0 for loads
//  data_wdata   out  32      SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata
//  data_addr_ok in   1       request accepted
//  data_data_ok in   1       read data returned / write completed
//  data_rdata   in   32      raw bus read word
// BEHAVIOUR
//  - adel_o/ades_o/bad_addr_o combinational from op_i, addr_i only (no mem_en_i: avoids loop via flush).
//    Half: addr[0]!=0; word: addr[1:0]!=0. Byte never faults. Non-memory op -> all 0.
//  - access = mem_en_i & ~adel_o & ~ades_o & ~flush_i; misaligned access never reaches bus.
//  - FSM: IDLE, REQ_WAIT, DATA_WAIT, DONE, DRAIN.
//    IDLE: access -> data_req=1, stallreq_o=1; addr_ok&data_ok -> DONE; addr_ok -> DATA_WAIT; else REQ_WAIT.
//    REQ_WAIT: data_req held with stable addr/size/wdata; same exits as IDLE; flush_i -> IDLE, req dropped.
//    DATA_WAIT: stallreq_o=1, data_req=0; data_ok -> DONE (latch data_rdata, op, addr[1:0]);
//      flush_i -> DRAIN (transaction already accepted must be consumed).
//    DONE: stallreq_o=0; rdata_o from latch; stall_ext_i=0 -> IDLE; else stay, rdata_o stable.
//    DRAIN: data_req=0; stallreq_o=mem_en_i; data_ok -> IDLE, data discarded.
//  - Min load latency: 1 stall cycle (addr_ok+data_ok in first cycle), result in following DONE cycle.
//  - Extension on latched word: LB/LBU pick byte addr[1:0], LH/LHU pick half addr[1]; LB/LH sign, LBU/LHU zero.
//  - Strobes: SB 0001<<addr[1:0]; SH 0011<<addr[1:0]; SW 1111.
//  - Stores complete identically (data_ok ends them); rdata_o unchanged by stores.
//  - Reset (rst=0): state IDLE; latch, rdata_o = 0; data_req, stallreq_o forced 0 regardless of inputs.
//  - Reset mid-transaction abandons it; bus side reset together.
//  - No new request issued in DRAIN/DONE; at most one outstanding transaction.
// TESTING
//  1. LB addr=0x...03, rdata=0x80FF_1234, addr_ok+data_ok cycle0 -> stallreq 1 cycle, rdata_o=0xFFFFFF80.
//  2. LHU addr=0x...02, addr_ok delayed 3 cycles, data_ok 2 later, rdata=0xBEEF0000 -> stall 6 cycles, rdata_o=0x0000BEEF.
//  3. SH addr=0x...01 -> ades_o=1, bad_addr_o=addr, data_req never 1; LW addr=0x...02 -> adel_o=1.
//  4. SB addr=0x...02 wdata=0x000000A5 -> data_wstrb=0100, data_wdata=0xA5A5A5A5, size=0, data_wr=1.
//  5. flush_i in DATA_WAIT -> DRAIN, stallreq_o=0 (no access), late data_ok discarded, next LW waits for DRAIN exit.
//  6. DONE with stall_ext_i=1 for 4 cycles -> rdata_o stable, no data_req; rst=0 mid-REQ_WAIT -> data_req=0 immediately.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: alignment checks, bus request handshake,
// pipeline stall generation and load-data extension.
module mem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              mem_en_i,
  input  logic              mem_we_i,
  input  logic              flush_i,
  input  logic              stall_ext_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              adel_o,
  output logic              ades_o,
  output logic [ADDR_W-1:0] bad_addr_o,
  output logic              stallreq_o,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [3:0]        data_wstrb,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata
);
  localparam logic [5:0] OP_LB = 6'b100000, OP_LBU = 6'b100100, OP_LH = 6'b100001,
                         OP_LHU = 6'b100101, OP_LW = 6'b100011, OP_SB = 6'b101000,
                         OP_SH = 6'b101001, OP_SW = 6'b101011;

  localparam logic [2:0] IDLE = 3'd0, REQ_WAIT = 3'd1, DATA_WAIT = 3'd2,
                         DONE = 3'd3, DRAIN = 3'd4;

  typedef struct packed {
    logic [DATA_W-1:0] word;
    logic [5:0]        op;
    logic [1:0]        off;
  } ldLatch_t;

  logic       isLoad, isStore, misal, access;
  logic [1:0] size;
  logic [2:0] state, nxt;
  logic       reqC, stallC, latchEn;
  ldLatch_t   lat;

  always_comb begin
    isLoad  = 1'b0;
    isStore = 1'b0;
    size    = 2'd0;
    case (op_i)
      OP_LB, OP_LBU:  isLoad = 1'b1;
      OP_LH, OP_LHU:  begin isLoad = 1'b1; size = 2'd1; end
      OP_LW:          begin isLoad = 1'b1; size = 2'd2; end
      OP_SB:          isStore = 1'b1;
      OP_SH:          begin isStore = 1'b1; size = 2'd1; end
      OP_SW:          begin isStore = 1'b1; size = 2'd2; end
      default: ;
    endcase
  end

  // Faults depend only on op/addr so flush (driven from these) cannot loop back.
  assign misal      = (size == 2'd1 && addr_i[0]) || (size == 2'd2 && addr_i[1:0] != 2'b00);
  assign adel_o     = isLoad & misal;
  assign ades_o     = isStore & misal;
  assign bad_addr_o = (adel_o | ades_o) ? addr_i : '0;
  assign access     = mem_en_i & (isLoad | isStore) & ~adel_o & ~ades_o & ~flush_i;

  assign data_wr   = mem_we_i;
  assign data_size = size;
  assign data_addr = addr_i;

  always_comb begin
    data_wstrb = 4'b0000;
    data_wdata = wdata_i;
    case (size)
      2'd0: begin
        data_wstrb = 4'b0001 << addr_i[1:0];
        data_wdata = {4{wdata_i[7:0]}};
      end
      2'd1: begin
        data_wstrb = 4'b0011 << addr_i[1:0];
        data_wdata = {2{wdata_i[15:0]}};
      end
      default: data_wstrb = 4'b1111;
    endcase
    if (!isStore) data_wstrb = 4'b0000;
  end

  always_comb begin
    nxt     = state;
    reqC    = 1'b0;
    stallC  = 1'b0;
    latchEn = 1'b0;
    case (state)
      IDLE, REQ_WAIT: begin
        // REQ_WAIT keeps the request up unless the instruction is flushed.
        if ((state == IDLE) ? access : !flush_i) begin
          reqC   = 1'b1;
          stallC = 1'b1;
          if (data_addr_ok && data_data_ok) begin
            nxt     = DONE;
            latchEn = 1'b1;
          end else if (data_addr_ok) nxt = DATA_WAIT;
          else                       nxt = REQ_WAIT;
        end else nxt = IDLE;
      end
      DATA_WAIT: begin
        stallC = 1'b1;
        if (data_data_ok) begin
          nxt     = DONE;
          latchEn = 1'b1;
        end else if (flush_i) nxt = DRAIN;
      end
      DONE:    if (!stall_ext_i) nxt = IDLE;
      DRAIN: begin
        stallC = mem_en_i;
        if (data_data_ok) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  assign data_req   = rst & reqC;
  assign stallreq_o = rst & stallC;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      lat   <= '0;
    end else begin
      state <= nxt;
      // Stores leave the load result untouched.
      if (latchEn && isLoad) lat <= '{word: data_rdata, op: op_i, off: addr_i[1:0]};
    end
  end

  logic [7:0]  bSel;
  logic [15:0] hSel;
  always_comb begin
    bSel = lat.word[8*lat.off +: 8];
    hSel = lat.off[1] ? lat.word[31:16] : lat.word[15:0];
    case (lat.op)
      OP_LB:   rdata_o = {{24{bSel[7]}}, bSel};
      OP_LBU:  rdata_o = {24'd0, bSel};
      OP_LH:   rdata_o = {{16{hSel[15]}}, hSel};
      OP_LHU:  rdata_o = {16'd0, hSel};
      default: rdata_o = lat.word;
    endcase
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit.
module tb_mem_access_unit;
  localparam logic [5:0] LB = 6'b100000, LBU = 6'b100100, LH = 6'b100001, LHU = 6'b100101,
                         LW = 6'b100011, SB = 6'b101000, SH = 6'b101001, SW = 6'b101011;

  logic        clk = 1'b0, rst = 1'b0;
  logic [5:0]  op = '0;
  logic [31:0] addr = '0, wdata = '0, busRdata = '0;
  logic        memEn = 1'b0, memWe = 1'b0, flush = 1'b0, stallExt = 1'b0;
  logic        addrOk = 1'b0, dataOk = 1'b0;
  logic [31:0] rdata, badAddr, dataAddr, dataWdata;
  logic        adel, ades, stallreq, dataReq, dataWr;
  logic [1:0]  dataSize;
  logic [3:0]  dataWstrb;
  int checks = 0, failures = 0;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .op_i(op), .addr_i(addr), .wdata_i(wdata),
    .mem_en_i(memEn), .mem_we_i(memWe), .flush_i(flush), .stall_ext_i(stallExt),
    .rdata_o(rdata), .adel_o(adel), .ades_o(ades), .bad_addr_o(badAddr),
    .stallreq_o(stallreq), .data_req(dataReq), .data_wr(dataWr), .data_size(dataSize),
    .data_addr(dataAddr), .data_wstrb(dataWstrb), .data_wdata(dataWdata),
    .data_addr_ok(addrOk), .data_data_ok(dataOk), .data_rdata(busRdata)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    op = LW; addr = 32'h100; memEn = 1'b1; addrOk = 1'b1; dataOk = 1'b1; #2;
    checks++; if ({dataReq, stallreq} !== 2'b00) begin failures++; $display("FAIL reset_req got=%b exp=00", {dataReq, stallreq}); end
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    step; step;
    checks++; if ({dataReq, stallreq} !== 2'b00) begin failures++; $display("FAIL reset_hold got=%b exp=00", {dataReq, stallreq}); end
    memEn = 1'b0; addrOk = 1'b0; dataOk = 1'b0; rst = 1'b1;
    step;
  endtask

  task automatic test_loads;
    op = LB; memWe = 1'b0; addr = 32'h1003; memEn = 1'b1; addrOk = 1'b1; dataOk = 1'b1;
    busRdata = 32'h80FF1234; #1;
    checks++; if ({dataReq, stallreq, dataWr} !== 3'b110) begin failures++; $display("FAIL lb_issue got=%b exp=110", {dataReq, stallreq, dataWr}); end
    checks++; if ({dataSize, dataWstrb} !== 6'b00_0000) begin failures++; $display("FAIL lb_size_strb got=%b exp=000000", {dataSize, dataWstrb}); end
    checks++; if (dataAddr !== 32'h1003) begin failures++; $display("FAIL lb_addr got=%h exp=00001003", dataAddr); end
    step; addrOk = 1'b0; dataOk = 1'b0; #1;
    checks++; if (stallreq !== 1'b0) begin failures++; $display("FAIL lb_done_stall got=%b exp=0", stallreq); end
    checks++; if (rdata !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_rdata got=%h exp=ffffff80", rdata); end
    memEn = 1'b0; step; #1;
    checks++; if (rdata !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_rdata_hold got=%h exp=ffffff80", rdata); end
    op = LH; addr = 32'h1000; memEn = 1'b1; addrOk = 1'b1; dataOk = 1'b1; busRdata = 32'h00008001;
    step; addrOk = 1'b0; dataOk = 1'b0; memEn = 1'b0; #1;
    checks++; if (rdata !== 32'hFFFF8001) begin failures++; $display("FAIL lh_rdata got=%h exp=ffff8001", rdata); end
    step;
    op = LBU; addr = 32'h1001; memEn = 1'b1; addrOk = 1'b1; dataOk = 1'b1; busRdata = 32'h00009A00;
    step; addrOk = 1'b0; dataOk = 1'b0; memEn = 1'b0; #1;
    checks++; if (rdata !== 32'h0000009A) begin failures++; $display("FAIL lbu_rdata got=%h exp=0000009a", rdata); end
    step;
  endtask

  task automatic test_lhu_delayed;
    int cnt = 0, reqBad = 0;
    op = LHU; addr = 32'h2002; memEn = 1'b1; busRdata = 32'hBEEF0000;
    for (int c = 0; c < 20; c++) begin
      addrOk = (c == 3); dataOk = (c == 5); #1;
      if (!stallreq) break;
      if (dataReq !== (c <= 3)) reqBad++;
      cnt++;
      step;
    end
    checks++; if (cnt !== 6) begin failures++; $display("FAIL lhu_stall_cycles got=%0d exp=6", cnt); end
    checks++; if (reqBad !== 0) begin failures++; $display("FAIL lhu_req_shape got=%0d bad cycles exp=0", reqBad); end
    checks++; if (rdata !== 32'h0000BEEF) begin failures++; $display("FAIL lhu_rdata got=%h exp=0000beef", rdata); end
    memEn = 1'b0; addrOk = 1'b0; dataOk = 1'b0;
    step;
  endtask

  task automatic test_misalign;
    logic reqSeen = 1'b0;
    op = SH; memWe = 1'b1; addr = 32'h3001; wdata = 32'h1234; memEn = 1'b1;
    addrOk = 1'b1; dataOk = 1'b1; #1;
    checks++; if ({ades, adel} !== 2'b10) begin failures++; $display("FAIL sh_ades got=%b exp=10", {ades, adel}); end
    checks++; if (badAddr !== 32'h3001) begin failures++; $display("FAIL sh_badaddr got=%h exp=00003001", badAddr); end
    for (int c = 0; c < 3; c++) begin
      if (dataReq !== 1'b0 || stallreq !== 1'b0) reqSeen = 1'b1;
      step;
    end
    checks++; if (reqSeen !== 1'b0) begin failures++; $display("FAIL sh_no_req got=%b exp=0", reqSeen); end
    op = LW; memWe = 1'b0; addr = 32'h3002; #1;
    checks++; if ({adel, ades, dataReq} !== 3'b100) begin failures++; $display("FAIL lw_adel got=%b exp=100", {adel, ades, dataReq}); end
    checks++; if (badAddr !== 32'h3002) begin failures++; $display("FAIL lw_badaddr got=%h exp=00003002", badAddr); end
    memEn = 1'b0; addrOk = 1'b0; dataOk = 1'b0;
    op = LB; addr = 32'h3003; #1;
    checks++; if ({adel, ades, badAddr} !== 34'h0) begin failures++; $display("FAIL lb_nofault got=%h exp=0", {adel, ades, badAddr}); end
    op = 6'b001000; #1;
    checks++; if ({adel, ades, badAddr} !== 34'h0) begin failures++; $display("FAIL nonmem_nofault got=%h exp=0", {adel, ades, badAddr}); end
    step;
  endtask

  task automatic test_stores;
    op = SB; memWe = 1'b1; addr = 32'h4002; wdata = 32'h000000A5; memEn = 1'b1;
    addrOk = 1'b1; dataOk = 1'b1; busRdata = 32'h55555555; #1;
    checks++; if (dataWstrb !== 4'b0100) begin failures++; $display("FAIL sb_strb got=%b exp=0100", dataWstrb); end
    checks++; if (dataWdata !== 32'hA5A5A5A5) begin failures++; $display("FAIL sb_wdata got=%h exp=a5a5a5a5", dataWdata); end
    checks++; if ({dataSize, dataWr, dataReq} !== 4'b0011) begin failures++; $display("FAIL sb_ctrl got=%b exp=0011", {dataSize, dataWr, dataReq}); end
    step; addrOk = 1'b0; dataOk = 1'b0; memEn = 1'b0; #1;
    checks++; if (rdata !== 32'h0000BEEF) begin failures++; $display("FAIL sb_rdata_keep got=%h exp=0000beef", rdata); end
    step;
    op = SB; addr = 32'h4003; #1;
    checks++; if (dataWstrb !== 4'b1000) begin failures++; $display("FAIL sb3_strb got=%b exp=1000", dataWstrb); end
    op = SH; addr = 32'h4002; wdata = 32'hFFFF1234; #1;
    checks++; if ({dataSize, dataWstrb} !== 6'b01_1100) begin failures++; $display("FAIL sh_strb got=%b exp=011100", {dataSize, dataWstrb}); end
    checks++; if (dataWdata !== 32'h12341234) begin failures++; $display("FAIL sh_wdata got=%h exp=12341234", dataWdata); end
    op = SW; addr = 32'h4004; wdata = 32'hDEADBEEF; #1;
    checks++; if ({dataSize, dataWstrb} !== 6'b10_1111) begin failures++; $display("FAIL sw_strb got=%b exp=101111", {dataSize, dataWstrb}); end
    checks++; if (dataWdata !== 32'hDEADBEEF) begin failures++; $display("FAIL sw_wdata got=%h exp=deadbeef", dataWdata); end
    memWe = 1'b0;
    step;
  endtask

  task automatic test_flush_drain;
    op = LW; addr = 32'h5000; memEn = 1'b1; addrOk = 1'b1; dataOk = 1'b0; #1;
    checks++; if (dataReq !== 1'b1) begin failures++; $display("FAIL fl_issue got=%b exp=1", dataReq); end
    step; addrOk = 1'b0; flush = 1'b1; #1;
    checks++; if (dataReq !== 1'b0) begin failures++; $display("FAIL fl_datawait_req got=%b exp=0", dataReq); end
    step; flush = 1'b0; memEn = 1'b0; #1;
    checks++; if ({dataReq, stallreq} !== 2'b00) begin failures++; $display("FAIL drain_idle got=%b exp=00", {dataReq, stallreq}); end
    step; addr = 32'h6000; memEn = 1'b1; #1;
    checks++; if ({dataReq, stallreq} !== 2'b01) begin failures++; $display("FAIL drain_newlw got=%b exp=01", {dataReq, stallreq}); end
    step; dataOk = 1'b1; busRdata = 32'hDEADDEAD; #1;
    checks++; if ({dataReq, stallreq} !== 2'b01) begin failures++; $display("FAIL drain_lateok got=%b exp=01", {dataReq, stallreq}); end
    step; dataOk = 1'b0; #1;
    checks++; if ({dataReq, stallreq} !== 2'b11) begin failures++; $display("FAIL drain_exit_req got=%b exp=11", {dataReq, stallreq}); end
    addrOk = 1'b1; dataOk = 1'b1; busRdata = 32'h11223344;
    step; addrOk = 1'b0; dataOk = 1'b0; #1;
    checks++; if (rdata !== 32'h11223344) begin failures++; $display("FAIL drain_next_rdata got=%h exp=11223344", rdata); end
    memEn = 1'b0;
    step;
  endtask

  task automatic test_back_to_back;
    op = LW; addr = 32'h7000; memEn = 1'b1; addrOk = 1'b1; dataOk = 1'b1;
    busRdata = 32'hCAFEF00D; stallExt = 1'b1;
    step; addrOk = 1'b0; dataOk = 1'b0; busRdata = 32'h0;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if ({rdata, dataReq, stallreq} !== {32'hCAFEF00D, 2'b00}) begin failures++; $display("FAIL ext_stall_hold c=%0d got=%h exp=cafef00d/00", c, {rdata, dataReq, stallreq}); end
      step;
    end
    stallExt = 1'b0;
    step; addr = 32'h7004; #1;
    checks++; if ({dataReq, stallreq} !== 2'b11) begin failures++; $display("FAIL b2b_issue got=%b exp=11", {dataReq, stallreq}); end
    step; #1;
    checks++; if ({dataReq, stallreq} !== 2'b11) begin failures++; $display("FAIL reqwait_hold got=%b exp=11", {dataReq, stallreq}); end
    rst = 1'b0; #1;
    checks++; if ({dataReq, stallreq} !== 2'b00) begin failures++; $display("FAIL midreset_req got=%b exp=00", {dataReq, stallreq}); end
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL midreset_rdata got=%h exp=0", rdata); end
    memEn = 1'b0;
    step; rst = 1'b1;
    step; #1;
    checks++; if ({dataReq, stallreq} !== 2'b00) begin failures++; $display("FAIL post_reset_idle got=%b exp=00", {dataReq, stallreq}); end
  endtask

  initial begin
    test_reset;
    test_loads;
    test_lhu_delayed;
    test_misalign;
    test_stores;
    test_flush_drain;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
